mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

MEM/WB pipeline register and writeback stage of the RISC-V core. It captures the memory-stage result and extracts and extends load data. It selects the writeback source and drives the general-purpose register file write port (address, enable, data). The register file writes on the falling edge, so a value registered here on a rising edge is readable by decode in the same cycle.

## Interface

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  hold every stage register.
- flush  in  1  replace the captured instruction with a bubble.
- in_valid  in  1  memory stage holds a real instruction.
- in_rd  in  5  destination register index.
- in_reg_write  in  1  instruction writes rd.
- in_wb_sel  in  2  writeback source: 00 ALU, 01 load, 10 pc+4, 11 immediate (LUI).
- in_load_type  in  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- in_alu_result  in  32  ALU result; also the load byte address.
- in_pc_plus4  in  32  link value for JAL/JALR.
- in_imm  in  32  U-type immediate.
- in_mem_rdata  in  32  raw aligned word from data memory.
- rf_addr  out  5  register file write address (Address3).
- rf_we  out  1  register file write enable (RegWriteEN3).
- rf_wdata  out  32  register file write data (RegDataW3).
- wb_valid  out  1  writeback stage holds a real instruction.

## Operation

- Load extraction uses off = in_alu_result[1:0] and is computed before capture.
  - Byte: in_mem_rdata[8*off+7 : 8*off].
  - Half: off[1]=0 selects bits [15:0]; off[1]=1 selects bits [31:16]. off[0] is ignored; misalignment is handled upstream.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
  - Undefined funct3 values (011, 110, 111) are treated as LW.
- Source mux on in_wb_sel produces the next-cycle value of rf_wdata.
- Write enable captured = in_valid & in_reg_write & (in_rd != 0). A write to x0 is never issued.
- Update priority at each rising edge:
  - rst: async clear.
  - flush: bubble.
  - stall: hold.
  - otherwise: capture.
- Bubble values: wb_valid=0, rf_we=0, rf_addr=0, rf_wdata=0.
- flush asserted together with stall produces a bubble; flush wins.
- When in_valid=0, the stage captures wb_valid=0 and rf_we=0. rf_addr and rf_wdata are still captured and are don't-care.

## Timing

- Latency: one cycle from the inputs to rf_* and wb_valid. All outputs are registered, with no combinational input-to-output path.
- The register file commits on the following falling edge, half a cycle after rf_we rises.
- During a stall, rf_we stays high if it was high. The register file rewrites the same value, which is harmless.
- Reset: all outputs are 0 while rst is high (wb_valid=0, rf_we=0, rf_addr=0, rf_wdata=0). Reset takes effect immediately, including mid-stall. The first capture happens on the first rising edge after rst deasserts.
- The retire counter (see Configuration) clears asynchronously on rst.

## Configuration

- Macro WB_INSTRET_EN.
- When defined:
  - Adds output instret [63:0], reset value 0.
  - The counter increments by 1 on every rising edge where wb_valid=1 and stall=0, whether or not that instruction writes a register.
  - It wraps from 2^64-1 to 0.
  - A flushed bubble does not count.
- When undefined: the instret port and the counter do not exist, and no counter logic is synthesized.

## Test plan

- Reset: drive in_* nonzero with rst=1. Required: rf_we=0, rf_addr=0, rf_wdata=0, wb_valid=0. Required under WB_INSTRET_EN: instret=0.
- Load extension with in_mem_rdata=0x80F17F82. Required results after one edge:
  - LB, off=0 -> 0xFFFFFF82.
  - LBU, off=0 -> 0x00000082.
  - LB, off=1 -> 0x0000007F.
  - LH, off=2 -> 0xFFFF80F1.
  - LHU, off=2 -> 0x000080F1.
  - LW -> 0x80F17F82.
- Source mux and x0: wb_sel=10, pc_plus4=0x00000104, rd=5. Required: rf_we=1, rf_addr=5, rf_wdata=0x104. The same with rd=0 requires rf_we=0.
- Stall/flush:
  - Capture rd=3 with ALU result 0x1234, then hold stall=1 for 3 cycles with new inputs. Required: outputs unchanged.
  - Then assert flush=1 and stall=1 together. Required: bubble next edge.
- Integration with the register file: write x7=0xDEADBEEF through this stage, with decode reading x7 in the same cycle. Required: decode reads 0xDEADBEEF after the falling edge.
- WB_INSTRET_EN: 10 valid instructions, 2 flushed bubbles and 3 stall cycles. Required: instret=10. Preload 0xFFFFFFFFFFFFFFFF and retire 1. Required: instret=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register: load extraction, writeback mux, register file write port.
// Optional retire counter enabled by defining WB_INSTRET_EN.
module mem_wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_write,
  input  logic [1:0]      in_wb_sel,
  input  logic [2:0]      in_load_type,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_mem_rdata,
  output logic [4:0]      rf_addr,
  output logic            rf_we,
  output logic [XLEN-1:0] rf_wdata,
  output logic            wb_valid
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]     instret
`endif
);

  logic [1:0]      off;
  logic [XLEN-1:0] shifted;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] wb_data;

  logic            valid_q, valid_d;
  logic            we_q, we_d;
  logic [4:0]      addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  assign off     = in_alu_result[1:0];
  assign shifted = in_mem_rdata >> {off, 3'b000};
  assign ld_byte = shifted[7:0];
  // Halfword picks by off[1] only; misaligned halves are trapped upstream.
  assign ld_half = off[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];

  always_comb begin
    load_data = in_mem_rdata;
    case (in_load_type)
      3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, ld_half};
      default: load_data = in_mem_rdata;
    endcase
  end

  always_comb begin
    wb_data = in_alu_result;
    case (in_wb_sel)
      2'b00:   wb_data = in_alu_result;
      2'b01:   wb_data = load_data;
      2'b10:   wb_data = in_pc_plus4;
      default: wb_data = in_imm;
    endcase
  end

  // Flush beats stall so a squashed instruction never lingers in writeback.
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (flush) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
      addr_d  = 5'd0;
      wdata_d = '0;
    end else if (!stall) begin
      valid_d = in_valid;
      we_d    = in_valid & in_reg_write & (in_rd != 5'd0);
      addr_d  = in_rd;
      wdata_d = wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 5'd0;
      wdata_q <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign rf_addr  = addr_q;
  assign rf_we    = we_q;
  assign rf_wdata = wdata_q;
  assign wb_valid = valid_q;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  // The instruction leaving writeback retires; flush only kills the incoming one.
  always_comb begin
    instret_d = instret_q;
    if (valid_q && !stall) instret_d = instret_q + 64'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) instret_q <= 64'd0;
    else     instret_q <= instret_d;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage (vector table plus scoreboard queue).
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, in_valid, in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_load_type;
  logic [31:0] in_alu_result, in_pc_plus4, in_imm, in_mem_rdata;
  logic [4:0]  rf_addr;
  logic        rf_we, wb_valid;
  logic [31:0] rf_wdata;
`ifdef WB_INSTRET_EN
  logic [63:0] instret;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_wb_sel(in_wb_sel), .in_load_type(in_load_type),
    .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
    .in_imm(in_imm), .in_mem_rdata(in_mem_rdata),
    .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata), .wb_valid(wb_valid)
`ifdef WB_INSTRET_EN
    , .instret(instret)
`endif
  );

  // Register file model: writes on the falling edge.
  logic [31:0] regs [32];
  always @(negedge clk) if (rf_we && rf_addr != 5'd0) regs[rf_addr] <= rf_wdata;

  typedef struct {
    logic        valid;
    logic        reg_write;
    logic [4:0]  rd;
    logic [1:0]  wb_sel;
    logic [2:0]  load_type;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [31:0] rdata;
    logic        e_valid;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        chk_data;
  } vec_t;

  typedef struct {
    string       name;
    logic        e_valid;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  vec_t vt[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic push_exp(input string nm, input logic v, input logic we,
                          input logic [4:0] a, input logic [31:0] d, input logic cd);
    exp_t e;
    e.name = nm; e.e_valid = v; e.e_we = we; e.e_addr = a; e.e_data = d; e.chk_data = cd;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({e.name, ".wb_valid"}, {63'd0, wb_valid}, {63'd0, e.e_valid});
      chk({e.name, ".rf_we"},    {63'd0, rf_we},    {63'd0, e.e_we});
      if (e.chk_data) begin
        chk({e.name, ".rf_addr"},  {59'd0, rf_addr},  {59'd0, e.e_addr});
        chk({e.name, ".rf_wdata"}, {32'd0, rf_wdata}, {32'd0, e.e_data});
      end
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] ws,
                       input logic [2:0] lt, input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [31:0] imm, input logic [31:0] rdata);
    in_valid = v; in_reg_write = rw; in_rd = rd; in_wb_sel = ws; in_load_type = lt;
    in_alu_result = alu; in_pc_plus4 = pc4; in_imm = imm; in_mem_rdata = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] ws,
                         input logic [2:0] lt, input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [31:0] imm, input logic [31:0] rdata, input logic ev,
                         input logic ew, input logic [4:0] ea, input logic [31:0] ed, input logic cd);
    vec_t x;
    x.valid = v; x.reg_write = rw; x.rd = rd; x.wb_sel = ws; x.load_type = lt;
    x.alu = alu; x.pc4 = pc4; x.imm = imm; x.rdata = rdata;
    x.e_valid = ev; x.e_we = ew; x.e_addr = ea; x.e_data = ed; x.chk_data = cd;
    vt.push_back(x);
  endtask

  localparam logic [31:0] MD = 32'h80F1_7F82;

  initial begin
    // Vector table: loads, source mux, x0 suppression, invalid slot.
    add_vec(1, 1, 5'd1, 2'b01, 3'b000, 32'h1000, 0, 0, MD, 1, 1, 5'd1, 32'hFFFF_FF82, 1);
    add_vec(1, 1, 5'd2, 2'b01, 3'b100, 32'h1000, 0, 0, MD, 1, 1, 5'd2, 32'h0000_0082, 1);
    add_vec(1, 1, 5'd3, 2'b01, 3'b000, 32'h1001, 0, 0, MD, 1, 1, 5'd3, 32'h0000_007F, 1);
    add_vec(1, 1, 5'd4, 2'b01, 3'b001, 32'h1002, 0, 0, MD, 1, 1, 5'd4, 32'hFFFF_80F1, 1);
    add_vec(1, 1, 5'd6, 2'b01, 3'b101, 32'h1002, 0, 0, MD, 1, 1, 5'd6, 32'h0000_80F1, 1);
    add_vec(1, 1, 5'd8, 2'b01, 3'b010, 32'h1000, 0, 0, MD, 1, 1, 5'd8, 32'h80F1_7F82, 1);
    add_vec(1, 1, 5'd9, 2'b01, 3'b000, 32'h1003, 0, 0, MD, 1, 1, 5'd9, 32'hFFFF_FF80, 1);
    add_vec(1, 1, 5'd10, 2'b01, 3'b001, 32'h1003, 0, 0, MD, 1, 1, 5'd10, 32'hFFFF_80F1, 1);
    add_vec(1, 1, 5'd11, 2'b01, 3'b011, 32'h1001, 0, 0, MD, 1, 1, 5'd11, 32'h80F1_7F82, 1);
    add_vec(1, 1, 5'd12, 2'b01, 3'b101, 32'h1001, 0, 0, MD, 1, 1, 5'd12, 32'h0000_7F82, 1);
    add_vec(1, 1, 5'd5, 2'b10, 3'b010, 32'h55, 32'h104, 32'h7000, MD, 1, 1, 5'd5, 32'h0000_0104, 1);
    add_vec(1, 1, 5'd0, 2'b10, 3'b010, 32'h55, 32'h104, 32'h7000, MD, 1, 0, 5'd0, 32'h0000_0104, 1);
    add_vec(1, 1, 5'd13, 2'b11, 3'b010, 32'h55, 32'h104, 32'h7000, MD, 1, 1, 5'd13, 32'h0000_7000, 1);
    add_vec(1, 1, 5'd14, 2'b00, 3'b010, 32'hCAFE, 32'h104, 32'h7000, MD, 1, 1, 5'd14, 32'h0000_CAFE, 1);
    add_vec(1, 0, 5'd15, 2'b00, 3'b010, 32'hCAFE, 32'h104, 32'h7000, MD, 1, 0, 5'd15, 32'h0000_CAFE, 1);
    add_vec(0, 1, 5'd16, 2'b00, 3'b010, 32'hCAFE, 32'h104, 32'h7000, MD, 0, 0, 5'd0, 32'h0, 0);

    // Reset with nonzero inputs.
    stall = 0; flush = 0; rst = 1;
    drive(1, 1, 5'd7, 2'b10, 3'b000, 32'hFFFF_FFFF, 32'h1234, 32'h5678, 32'hFFFF_FFFF);
    tick(); tick();
    push_exp("reset", 0, 0, 5'd0, 32'd0, 1);
    pop_check();
`ifdef WB_INSTRET_EN
    chk("reset.instret", instret, 64'd0);
`endif
    #2 rst = 0;

    foreach (vt[i]) begin
      drive(vt[i].valid, vt[i].reg_write, vt[i].rd, vt[i].wb_sel, vt[i].load_type,
            vt[i].alu, vt[i].pc4, vt[i].imm, vt[i].rdata);
      push_exp($sformatf("vec%0d", i), vt[i].e_valid, vt[i].e_we, vt[i].e_addr,
               vt[i].e_data, vt[i].chk_data);
      tick();
      pop_check();
    end

    // Stall hold, then flush+stall bubble.
    drive(1, 1, 5'd3, 2'b00, 3'b010, 32'h1234, 0, 0, 0);
    push_exp("stall_cap", 1, 1, 5'd3, 32'h1234, 1);
    tick(); pop_check();
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 5'(20 + k), 2'b11, 3'b010, 32'h9999, 0, 32'hAAAA_0000 + k, 0);
      push_exp($sformatf("stall_hold%0d", k), 1, 1, 5'd3, 32'h1234, 1);
      tick(); pop_check();
    end
    flush = 1;
    push_exp("flush_stall", 0, 0, 5'd0, 32'd0, 1);
    tick(); pop_check();
    stall = 0; flush = 0;

    // Flush alone after a capture.
    drive(1, 1, 5'd17, 2'b00, 3'b010, 32'h4321, 0, 0, 0);
    push_exp("flush_pre", 1, 1, 5'd17, 32'h4321, 1);
    tick(); pop_check();
    flush = 1;
    push_exp("flush_only", 0, 0, 5'd0, 32'd0, 1);
    tick(); pop_check();
    flush = 0;

    // Asynchronous reset mid-stall clears outputs without a clock edge.
    drive(1, 1, 5'd18, 2'b00, 3'b010, 32'h7777, 0, 0, 0);
    tick();
    stall = 1;
    #2 rst = 1;
    #1;
    push_exp("async_rst", 0, 0, 5'd0, 32'd0, 1);
    pop_check();
    @(negedge clk);
    rst = 0; stall = 0;

    // Register file integration: decode sees x7 after the falling edge.
    drive(1, 1, 5'd7, 2'b00, 3'b010, 32'hDEAD_BEEF, 0, 0, 0);
    tick();
    drive(0, 0, 5'd0, 2'b00, 3'b010, 0, 0, 0, 0);
    @(negedge clk); #1;
    chk("rf_x7", {32'd0, regs[7]}, 64'h0000_0000_DEAD_BEEF);

`ifdef WB_INSTRET_EN
    rst = 1; #2; rst = 0;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      drive(1, 0, 5'd1, 2'b00, 3'b010, k, 0, 0, 0);
      tick();
    end
    drive(1, 1, 5'd1, 2'b00, 3'b010, 0, 0, 0, 0);
    flush = 1; tick(); tick(); flush = 0;
    stall = 1; tick(); tick(); tick(); stall = 0;
    drive(0, 0, 5'd0, 2'b00, 3'b010, 0, 0, 0, 0);
    tick(); tick();
    chk("instret_count", instret, 64'd10);
    drive(1, 1, 5'd2, 2'b00, 3'b010, 1, 0, 0, 0);
    tick();
    drive(0, 0, 5'd0, 2'b00, 3'b010, 0, 0, 0, 0);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.instret_q;
    tick();
    chk("instret_wrap", instret, 64'd0);
`endif

    if (sb.size() != 0) chk("scoreboard_leftover", sb.size(), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, required finished");
    $fatal(1, "timeout");
  end

endmodule
